decode_exec_skid_reg: RTL and testbench
=======================================

# decode_exec_skid_reg

- Registered decode→execute boundary of the predecode pipeline: 2-entry skid buffer carrying the 220-bit decode bundle {inst, A_data, B_data, control_data, alucontrol_data, PC}.
- Upstream is the decode/predecode stage; downstream is the execute-side bundle interpreter, which consumes `out_data` unchanged.
- Breaks the combinational ready path between execute and decode, squashes contents on flush, and zeroes empty slots so downstream decoding sees a harmless bubble.
- Counts execute back-pressure cycles for performance analysis.

## Interface
- `W`, 220: bundle width; field layout comes from the shared package.
- `CNT_W`, 32: stall counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decode presents a bundle.
- `in_ready` out 1: buffer can accept; equals `!skid_valid`, driven only from a flop.
- `in_data` in W: bundle from decode.
- `out_valid` out 1: head slot holds a valid bundle.
- `out_ready` in 1: execute accepts the head this cycle.
- `out_data` out W: head bundle; all-zero whenever `out_valid`=0.
- `flush` in 1: branch/jump redirect; squash everything held and arriving.
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`; saturates at all-ones.

## Operation
- State: head slot {head_valid, head_data}, skid slot {skid_valid, skid_data}. `out_valid`=head_valid, `out_data`=head_data.
- Handshake definitions: acc_in = in_valid & in_ready; acc_out = head_valid & out_ready.
- Invariant: skid_valid implies head_valid. The bundle order out equals the order in; nothing is duplicated or dropped except on flush.
- Next state when flush=0:
  - head empty: if acc_in, head ← in_data.
  - head full, acc_out, skid full: head ← skid, skid empties. No acc_in is possible in this case because in_ready=0.
  - head full, acc_out, skid empty: if acc_in, head ← in_data; otherwise head empties and head_data ← 0.
  - head full, no acc_out, acc_in: skid ← in_data. Skid must be empty here because in_ready=1.
  - head full, no acc_out, no acc_in: hold.
- flush=1 takes priority over all cases:
  - both valids ← 0 and both data registers ← 0.
  - An in_data arriving in the same cycle is dropped, even though in_ready may read 1.
  - An acc_out in the flush cycle still counts as delivered this cycle.
- A zeroed bundle gives control_reg_write=0, mem_wen_pick=0, r_type=0 and jump bits 0, so it behaves as a NOP downstream.
- stall_cnt:
  - increments by 1 on every cycle with head_valid & !out_ready, including a flush cycle.
  - holds at 2^CNT_W−1.
  - cleared only by rst.

## Timing
- Latency: in_data accepted in cycle N appears on out_data in cycle N+1 when the head is free; otherwise it appears after every older bundle has left.
- Throughput: 1 bundle/cycle with out_ready held high.
- in_ready falls the cycle after a bundle enters the skid slot. It rises the cycle after the skid slot drains into the head.
- Values while rst is asserted and immediately after deassertion:
  - out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
  - both slots empty.
- Reset asserted mid-operation clears all state immediately (asynchronous); held bundles are lost.
- flush takes effect at the next clock edge. out_valid=0 from the following cycle.

## Structure
- Shared package (`pipe_pkg`) holds:
  - `PIPE_W`=220.
  - Field widths: inst 32, A 32, B 32, control 54, alucontrol 38, PC 32.
  - Field offsets.
  - `BUBBLE` = all-zero constant.
- One sub-module, `pipe_slot`:
  - contents: valid flag plus W-bit data register with load/clear enables and asynchronous reset.
  - instantiated twice, once for the head slot and once for the skid slot.
- Slot steering and stall counter live in the top module.

## Test plan
- Reset: assert rst mid-stream → out_valid=0, out_data=0, in_ready=1, stall_cnt=0 the same cycle.
- Streaming: out_ready=1, bundles with PC=0x100,0x104,0x108 on consecutive cycles → same PCs on out_data cycles 1,2,3 in order; in_ready stays 1.
- Back-pressure: out_ready=0 from cycle 2, feed 0x100,0x104,0x108 → head=0x100, skid=0x104, in_ready=0 from cycle 3, 0x108 held by decode. Release out_ready → output 0x100,0x104,0x108 with no gap or loss; stall_cnt equals the number of cycles out_ready was low with out_valid=1.
- Flush with both slots full plus in_valid=1 → next cycle out_valid=0, out_data=0, in_ready=1; the arriving bundle never appears on the output.
- Simultaneous acc_out and acc_in with skid empty → head replaced by the new bundle in one cycle; skid stays empty.
- Counter saturation with CNT_W=4 and 20 stall cycles → stall_cnt=15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - decode bundle layout shared by predecode, skid register and execute
package pipe_pkg;

  // Bundle field widths, MSB-first order {inst, A, B, control, alucontrol, PC}
  localparam int INST_W = 32;
  localparam int A_W    = 32;
  localparam int B_W    = 32;
  localparam int CTRL_W = 54;
  localparam int ALU_W  = 38;
  localparam int PC_W   = 32;

  localparam int PIPE_W = INST_W + A_W + B_W + CTRL_W + ALU_W + PC_W;

  // Bit offsets of each field's LSB inside the flat bundle
  localparam int PC_OFF   = 0;
  localparam int ALU_OFF  = PC_OFF + PC_W;
  localparam int CTRL_OFF = ALU_OFF + ALU_W;
  localparam int B_OFF    = CTRL_OFF + CTRL_W;
  localparam int A_OFF    = B_OFF + B_W;
  localparam int INST_OFF = A_OFF + A_W;

  // All-zero bundle: every control bit clear, so execute treats it as a NOP
  localparam logic [PIPE_W-1:0] BUBBLE = '0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [A_W-1:0]    a_data;
    logic [B_W-1:0]    b_data;
    logic [CTRL_W-1:0] control_data;
    logic [ALU_W-1:0]  alucontrol_data;
    logic [PC_W-1:0]   pc;
  } bundle_t;

  // Assemble a flat bundle from its fields
  function automatic logic [PIPE_W-1:0] make_bundle(
    input logic [INST_W-1:0] inst,
    input logic [A_W-1:0]    a_data,
    input logic [B_W-1:0]    b_data,
    input logic [CTRL_W-1:0] control_data,
    input logic [ALU_W-1:0]  alucontrol_data,
    input logic [PC_W-1:0]   pc
  );
    bundle_t b;
    b.inst            = inst;
    b.a_data          = a_data;
    b.b_data          = b_data;
    b.control_data    = control_data;
    b.alucontrol_data = alucontrol_data;
    b.pc              = pc;
    return b;
  endfunction

  // Extract the PC field from a flat bundle
  function automatic logic [PC_W-1:0] bundle_pc(input logic [PIPE_W-1:0] data);
    return data[PC_OFF +: PC_W];
  endfunction

endpackage

// File: rtl/decode_exec_skid_reg_if.sv
// rtl/decode_exec_skid_reg_if.sv - decode/execute handshake bundle around the skid register
interface decode_exec_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int W = PIPE_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;

  // Pipeline environment: decode drives the input side, execute the ready, branch unit the flush
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // The skid register itself
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+data pipeline slot with load/clear enables
module pipe_slot #(
  parameter int W = 220
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] data
);

  // Clear wins over load so a flush always leaves the slot empty and zeroed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end
  end

endmodule

// File: rtl/decode_exec_skid_reg.sv
// rtl/decode_exec_skid_reg.sv - two-entry skid buffer between decode and execute
module decode_exec_skid_reg
  import pipe_pkg::*;
#(
  parameter int W     = PIPE_W,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  decode_exec_skid_reg_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic         head_valid;
  logic [W-1:0] head_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;

  logic         head_load;
  logic         head_clear;
  logic [W-1:0] head_d;
  logic         skid_load;
  logic         skid_clear;
  logic         skid_valid_next;
  logic         ready_q;

  logic         acc_in;
  logic         acc_out;

  assign acc_in  = bus.in_valid & ready_q;
  assign acc_out = head_valid & bus.out_ready;

  // Slot steering: head takes skid first to keep order, otherwise fresh input
  always_comb begin
    head_load  = 1'b0;
    head_clear = 1'b0;
    head_d     = bus.in_data;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (bus.flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!head_valid) begin
      head_load = acc_in;
    end else if (acc_out) begin
      if (skid_valid) begin
        head_load  = 1'b1;
        head_d     = skid_data;
        skid_clear = 1'b1;
      end else if (acc_in) begin
        head_load = 1'b1;
      end else begin
        head_clear = 1'b1;
      end
    end else if (acc_in) begin
      skid_load = 1'b1;
    end
  end

  // Skid occupancy after this edge; drives the registered ready
  assign skid_valid_next = !bus.flush &&
                           (skid_load || (skid_valid && !skid_clear));

  pipe_slot #(.W(W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .valid (head_valid),
    .data  (head_data)
  );

  pipe_slot #(.W(W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (bus.in_data),
    .valid (skid_valid),
    .data  (skid_data)
  );

  // Ready is its own flop so execute's out_ready never reaches decode combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= !skid_valid_next;
    end
  end

  // Back-pressure counter, saturating at all-ones, flush cycles included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (head_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;

endmodule

// File: tb/tb_decode_exec_skid_reg.sv
// tb/tb_decode_exec_skid_reg.sv - directed self-checking bench for decode_exec_skid_reg
module tb_decode_exec_skid_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] stall_a;
  logic [3:0]  stall_s;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_exec_skid_reg_if #(.W(PIPE_W)) bus_a ();
  decode_exec_skid_reg_if #(.W(PIPE_W)) bus_s ();

  decode_exec_skid_reg #(.W(PIPE_W), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_a.slave),
    .stall_cnt (stall_a)
  );

  decode_exec_skid_reg #(.W(PIPE_W), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_s.slave),
    .stall_cnt (stall_s)
  );

  function automatic logic [PIPE_W-1:0] bnd(input logic [31:0] pc);
    return make_bundle(pc ^ 32'hA500_0000, pc + 32'd1, pc + 32'd2,
                       {22'h2A_AAAA, pc}, {6'h15, pc}, pc);
  endfunction

  task automatic chk(input string tag, input logic [PIPE_W-1:0] obs,
                     input logic [PIPE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.out_ready = 0; bus_a.flush = 0;
    bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.out_ready = 0; bus_s.flush = 0;
    #2;
    chk("rst_out_valid", PIPE_W'(bus_a.out_valid), PIPE_W'(0));
    chk("rst_out_data", bus_a.out_data, BUBBLE);
    chk("rst_in_ready", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    chk("rst_stall", PIPE_W'(stall_a), PIPE_W'(0));
    step();
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    chk("post_rst_out_valid", PIPE_W'(bus_a.out_valid), PIPE_W'(0));

    // Streaming at full rate
    bus_a.out_ready = 1;
    bus_a.in_valid = 1; bus_a.in_data = bnd(32'h100);
    step();
    chk("stream_0", bus_a.out_data, bnd(32'h100));
    chk("stream_rdy0", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    bus_a.in_data = bnd(32'h104);
    step();
    chk("stream_1", bus_a.out_data, bnd(32'h104));
    chk("stream_rdy1", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    bus_a.in_data = bnd(32'h108);
    step();
    chk("stream_2", bus_a.out_data, bnd(32'h108));
    chk("stream_v2", PIPE_W'(bus_a.out_valid), PIPE_W'(1));
    bus_a.in_valid = 0;
    step();
    chk("stream_drain_v", PIPE_W'(bus_a.out_valid), PIPE_W'(0));
    chk("stream_drain_d", bus_a.out_data, BUBBLE);
    chk("stream_stall", PIPE_W'(stall_a), PIPE_W'(0));

    // Back-pressure: head + skid fill, decode holds the third
    bus_a.out_ready = 0;
    bus_a.in_valid = 1; bus_a.in_data = bnd(32'h100);
    step();
    chk("bp_head", bus_a.out_data, bnd(32'h100));
    chk("bp_rdy_a", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    bus_a.in_data = bnd(32'h104);
    step();
    chk("bp_head_hold", bus_a.out_data, bnd(32'h100));
    chk("bp_rdy_low", PIPE_W'(bus_a.in_ready), PIPE_W'(0));
    chk("bp_stall1", PIPE_W'(stall_a), PIPE_W'(1));
    bus_a.in_data = bnd(32'h108);
    step();
    chk("bp_head_hold2", bus_a.out_data, bnd(32'h100));
    chk("bp_rdy_low2", PIPE_W'(bus_a.in_ready), PIPE_W'(0));
    bus_a.out_ready = 1;
    step();
    chk("bp_out1", bus_a.out_data, bnd(32'h104));
    chk("bp_rdy_rise", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    step();
    chk("bp_out2", bus_a.out_data, bnd(32'h108));
    chk("bp_out2_v", PIPE_W'(bus_a.out_valid), PIPE_W'(1));
    bus_a.in_valid = 0;
    step();
    chk("bp_empty", PIPE_W'(bus_a.out_valid), PIPE_W'(0));
    chk("bp_stall", PIPE_W'(stall_a), PIPE_W'(2));

    // Flush with both slots full and a bundle arriving
    bus_a.out_ready = 0;
    bus_a.in_valid = 1; bus_a.in_data = bnd(32'h200);
    step();
    bus_a.in_data = bnd(32'h204);
    step();
    chk("fl_full_rdy", PIPE_W'(bus_a.in_ready), PIPE_W'(0));
    bus_a.in_data = bnd(32'h208);
    bus_a.flush = 1;
    step();
    chk("fl_v", PIPE_W'(bus_a.out_valid), PIPE_W'(0));
    chk("fl_d", bus_a.out_data, BUBBLE);
    chk("fl_rdy", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    chk("fl_stall", PIPE_W'(stall_a), PIPE_W'(4));
    bus_a.flush = 0; bus_a.in_valid = 0; bus_a.out_ready = 1;
    step();
    chk("fl_no_ghost", PIPE_W'(bus_a.out_valid), PIPE_W'(0));

    // Flush while in_ready=1: the arriving bundle is still dropped
    bus_a.out_ready = 0;
    bus_a.in_valid = 1; bus_a.in_data = bnd(32'h300);
    step();
    bus_a.in_data = bnd(32'h304);
    bus_a.flush = 1;
    step();
    bus_a.flush = 0; bus_a.in_valid = 0;
    chk("fl2_v", PIPE_W'(bus_a.out_valid), PIPE_W'(0));
    step();
    chk("fl2_no_ghost", PIPE_W'(bus_a.out_valid), PIPE_W'(0));
    chk("fl2_stall", PIPE_W'(stall_a), PIPE_W'(5));

    // Asynchronous reset mid-stream with both slots full
    bus_a.in_valid = 1; bus_a.in_data = bnd(32'h400);
    step();
    bus_a.in_data = bnd(32'h404);
    step();
    bus_a.in_valid = 0;
    rst = 1'b1;
    #1;
    chk("mrst_v", PIPE_W'(bus_a.out_valid), PIPE_W'(0));
    chk("mrst_d", bus_a.out_data, BUBBLE);
    chk("mrst_rdy", PIPE_W'(bus_a.in_ready), PIPE_W'(1));
    chk("mrst_stall", PIPE_W'(stall_a), PIPE_W'(0));
    step();
    rst = 1'b0;
    bus_a.out_ready = 1;
    step();
    chk("mrst_lost", PIPE_W'(bus_a.out_valid), PIPE_W'(0));

    // Saturation on the 4-bit counter instance
    bus_s.in_valid = 1; bus_s.in_data = bnd(32'h500);
    step();
    bus_s.in_valid = 0;
    repeat (14) step();
    chk("sat_14", PIPE_W'(stall_s), PIPE_W'(14));
    repeat (6) step();
    chk("sat_15", PIPE_W'(stall_s), PIPE_W'(15));
    chk("sat_head", bus_s.out_data, bnd(32'h500));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
